// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
// Imported by the loader top level and its word packer.
package imem_loader_pkg;

    localparam int LEN_W = 16;
    localparam logic [7:0] CSUM_INIT = 8'h00;

    typedef enum logic [2:0] {
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

endpackage

// File: rtl/imem_loader_word_packer.sv
// Packs four stream bytes, MSB first, into one 32-bit word.
// word_valid pulses combinationally with the 4th push of a word.
module imem_word_packer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  logic [7:0]  rx_byte,
    input  logic        clear,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [1:0]  cnt;
    logic [23:0] sr;

    assign word_valid = push && (cnt == 2'd3);
    assign word       = {sr, rx_byte};

    // byte counter and shift register; clear drops any partial word
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            cnt <= 2'd0;
            sr  <= 24'd0;
        end else if (push) begin
            cnt <= cnt + 2'd1;
            sr  <= {sr[15:0], rx_byte};
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: length header, big-endian word packing, XOR checksum.
// Writes instruction memory and holds the CPU until the image is good.
import imem_loader_pkg::*;

module imem_loader #(
    parameter int ADDR_W = 13
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);

    localparam logic [31:0] MAX_WORDS = 32'(1) << ADDR_W;

    state_t             state;
    state_t             state_next;
    logic [7:0]         len_hi;
    logic [LEN_W-1:0]   len;
    logic [LEN_W-1:0]   len_full;
    logic [ADDR_W:0]    word_idx;
    logic [7:0]         csum;
    logic               accept;
    logic               push;
    logic               clear;
    logic               word_valid;
    logic               last_word;
    logic [31:0]        word;

    // rx_ready is gated by rst_n so nothing is taken while in reset
    assign rx_ready = rst_n && (state == S_LEN_HI || state == S_LEN_LO ||
                                state == S_DATA   || state == S_CSUM);
    assign accept    = rx_valid && rx_ready;
    assign len_full  = {len_hi, rx_data};
    assign push      = accept && (state == S_DATA);
    assign clear     = accept && (state == S_LEN_LO);
    assign last_word = (LEN_W'(word_idx) + LEN_W'(1)) == len;

    assign done     = (state == S_DONE);
    assign error    = (state == S_ERR);
    assign cpu_hold = (state != S_DONE);

    imem_word_packer u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .rx_byte    (rx_data),
        .clear      (clear),
        .word_valid (word_valid),
        .word       (word)
    );

    // state register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_LEN_HI;
        else        state <= state_next;
    end

    // next-state logic; S_DONE and S_ERR are terminal until reset
    always_comb begin
        state_next = state;
        case (state)
            S_LEN_HI: begin
                if (accept) state_next = S_LEN_LO;
            end
            S_LEN_LO: begin
                if (accept) begin
                    if (32'(len_full) > MAX_WORDS) state_next = S_ERR;
                    else if (len_full == '0)       state_next = S_CSUM;
                    else                           state_next = S_DATA;
                end
            end
            S_DATA: begin
                if (word_valid && last_word) state_next = S_CSUM;
            end
            S_CSUM: begin
                if (accept) state_next = (rx_data == csum) ? S_DONE : S_ERR;
            end
            default: state_next = state;
        endcase
    end

    // header length, word index and running checksum
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            len_hi   <= 8'd0;
            len      <= '0;
            word_idx <= '0;
            csum     <= CSUM_INIT;
        end else begin
            if (accept && state == S_LEN_HI) len_hi <= rx_data;
            if (clear) begin
                len      <= len_full;
                word_idx <= '0;
                csum     <= CSUM_INIT;
            end
            if (push)       csum     <= csum ^ rx_data;
            if (word_valid) word_idx <= word_idx + 1'b1;
        end
    end

    // registered write port: one strobe cycle per completed word
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            im_we    <= 1'b0;
            im_addr  <= '0;
            im_wdata <= 32'd0;
        end else begin
            im_we <= word_valid;
            if (word_valid) begin
                im_addr  <= word_idx[ADDR_W-1:0];
                im_wdata <= word;
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: streams images built from a word
// list, and compares captured writes and status against that list.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_ready;
    logic        im_we;
    logic [12:0] im_addr;
    logic [31:0] im_wdata;
    logic        cpu_hold;
    logic        done;
    logic        error;

    int checks = 0;
    int failures = 0;

    logic [7:0]  stream[$];
    logic [31:0] img[$];
    logic [44:0] wq[$];
    int          we_run = 0;
    int          we_run_max = 0;

    imem_loader #(.ADDR_W(13)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .rx_ready (rx_ready),
        .im_we    (im_we),
        .im_addr  (im_addr),
        .im_wdata (im_wdata),
        .cpu_hold (cpu_hold),
        .done     (done),
        .error    (error)
    );

    always #5 clk = ~clk;

    // write monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (im_we) begin
            wq.push_back({im_addr, im_wdata});
            we_run = we_run + 1;
        end else begin
            we_run = 0;
        end
        if (we_run > we_run_max) we_run_max = we_run;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic reset_dut;
        @(negedge clk);
        rst_n = 1'b0;
        rx_valid = 1'($urandom_range(1));
        rx_data = 8'($urandom);
        repeat (2) @(posedge clk);
        wq.delete();
        we_run_max = 0;
        @(negedge clk);
        rst_n = 1'b1;
        rx_valid = 1'b0;
    endtask

    // stream = LEN_HI, LEN_LO, payload MSB first, XOR of payload ^ flip
    task automatic build(input logic [15:0] n, input logic [7:0] flip);
        logic [7:0] x;
        logic [7:0] b;
        x = 8'h00;
        stream.delete();
        stream.push_back(n[15:8]);
        stream.push_back(n[7:0]);
        foreach (img[i]) begin
            for (int k = 3; k >= 0; k--) begin
                b = img[i][k*8 +: 8];
                x = x ^ b;
                stream.push_back(b);
            end
        end
        stream.push_back(x ^ flip);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t;
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data = b;
        t = 0;
        while (!rx_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!rx_ready) begin
            checks++;
            failures++;
            $display("FAIL rx_ready_timeout got=0 exp=1");
        end else begin
            @(posedge clk);
        end
    endtask

    task automatic send_range(input int first, input int last, input int gap_pct);
        int g;
        for (int i = first; i <= last; i++) begin
            g = ($urandom_range(99) < gap_pct) ? $urandom_range(1, 4) : 0;
            repeat (g) begin
                @(negedge clk);
                rx_valid = 1'b0;
                rx_data = 8'($urandom);
            end
            send_byte(stream[i]);
        end
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        rst_n = 1'b0;
        rx_valid = 1'b1;
        rx_data = 8'hA5;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (rx_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_rx_ready got=%b exp=0", rx_ready);
        end
        checks++;
        if ({im_we, im_addr, im_wdata} !== 46'd0) begin
            failures++;
            $display("FAIL reset_wport got=%b/%h/%h exp=0/0/0", im_we, im_addr, im_wdata);
        end
        checks++;
        if ({cpu_hold, done, error} !== 3'b100) begin
            failures++;
            $display("FAIL reset_status got=%b exp=100", {cpu_hold, done, error});
        end
        rst_n = 1'b1;
        rx_valid = 1'b0;
        #1;
        checks++;
        if (rx_ready !== 1'b1) begin
            failures++;
            $display("FAIL idle_rx_ready got=%b exp=1", rx_ready);
        end
    endtask

    task automatic test_basic;
        reset_dut();
        img.delete();
        img.push_back(32'h20080005);
        img.push_back(32'h01095020);
        build(16'd2, 8'h00);
        send_range(0, stream.size() - 1, 0);
        checks++;
        if ({done, cpu_hold, error, rx_ready} !== 4'b1000) begin
            failures++;
            $display("FAIL basic_status got=%b exp=1000", {done, cpu_hold, error, rx_ready});
        end
        repeat (3) @(negedge clk);
        checks++;
        if (wq.size() != 2) begin
            failures++;
            $display("FAIL basic_count got=%0d exp=2", wq.size());
        end
        foreach (img[i]) begin
            checks++;
            if (i >= wq.size() || wq[i] !== {13'(i), img[i]}) begin
                failures++;
                $display("FAIL basic_write%0d got=%h exp=%h", i,
                         (i < wq.size()) ? wq[i] : 45'h0, {13'(i), img[i]});
            end
        end
    endtask

    task automatic test_bad_csum;
        reset_dut();
        img.delete();
        img.push_back(32'h20080005);
        img.push_back(32'h01095020);
        build(16'd2, 8'h01);
        send_range(0, stream.size() - 1, 0);
        checks++;
        if ({error, cpu_hold, done, rx_ready} !== 4'b1100) begin
            failures++;
            $display("FAIL badcsum_status got=%b exp=1100", {error, cpu_hold, done, rx_ready});
        end
        repeat (3) @(negedge clk);
        checks++;
        if (wq.size() != 2 || wq[1] !== {13'd1, img[1]}) begin
            failures++;
            $display("FAIL badcsum_writes got=%0d exp=2", wq.size());
        end
    endtask

    task automatic test_lengths;
        reset_dut();
        img.delete();
        build(16'd0, 8'h00);
        send_range(0, stream.size() - 1, 0);
        repeat (2) @(negedge clk);
        checks++;
        if ({done, cpu_hold, error} !== 3'b100 || wq.size() != 0) begin
            failures++;
            $display("FAIL zero_len got=%b/%0d exp=100/0", {done, cpu_hold, error}, wq.size());
        end
        reset_dut();
        stream.delete();
        stream.push_back(8'h20);
        stream.push_back(8'h01);
        send_range(0, 1, 0);
        checks++;
        if ({error, cpu_hold, done, rx_ready} !== 4'b1100) begin
            failures++;
            $display("FAIL too_long got=%b exp=1100", {error, cpu_hold, done, rx_ready});
        end
        repeat (2) @(negedge clk);
        checks++;
        if (wq.size() != 0) begin
            failures++;
            $display("FAIL too_long_writes got=%0d exp=0", wq.size());
        end
    endtask

    task automatic test_gaps;
        for (int r = 0; r < 3; r++) begin
            reset_dut();
            img.delete();
            for (int i = 0; i < 3; i++) img.push_back($urandom);
            build(16'd3, 8'h00);
            send_range(0, stream.size() - 1, 40);
            repeat (3) @(negedge clk);
            checks++;
            if (!done || wq.size() != 3) begin
                failures++;
                $display("FAIL gaps_done got=%b/%0d exp=1/3", done, wq.size());
            end
            for (int i = 0; i < 3 && i < wq.size(); i++) begin
                checks++;
                if (wq[i] !== {13'(i), img[i]}) begin
                    failures++;
                    $display("FAIL gaps_write%0d got=%h exp=%h", i, wq[i], {13'(i), img[i]});
                end
            end
            checks++;
            if (we_run_max != 1) begin
                failures++;
                $display("FAIL gaps_we_width got=%0d exp=1", we_run_max);
            end
        end
    endtask

    task automatic test_reset_abort;
        reset_dut();
        img.delete();
        img.push_back($urandom);
        img.push_back($urandom);
        build(16'd2, 8'h00);
        send_range(0, 7, 0);
        @(negedge clk);
        rst_n = 1'b0;
        rx_valid = 1'b1;
        rx_data = 8'($urandom);
        @(posedge clk);
        wq.delete();
        @(negedge clk);
        checks++;
        if (rx_ready !== 1'b0 || cpu_hold !== 1'b1) begin
            failures++;
            $display("FAIL abort_in_reset got=%b%b exp=01", rx_ready, cpu_hold);
        end
        rst_n = 1'b1;
        rx_valid = 1'b0;
        img.delete();
        img.push_back(32'hDEADBEEF);
        build(16'd1, 8'h00);
        send_range(0, stream.size() - 1, 0);
        repeat (3) @(negedge clk);
        checks++;
        if (wq.size() != 1 || wq[0] !== {13'd0, 32'hDEADBEEF}) begin
            failures++;
            $display("FAIL abort_reload got=%0d/%h exp=1/%h", wq.size(),
                     (wq.size() > 0) ? wq[0] : 45'h0, {13'd0, 32'hDEADBEEF});
        end
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL abort_done got=%b exp=1", done);
        end
    endtask

    task automatic test_full_image;
        int bad;
        int zero_hits;
        reset_dut();
        img.delete();
        for (int i = 0; i < 8192; i++) img.push_back($urandom);
        build(16'd8192, 8'h00);
        send_range(0, stream.size() - 1, 0);
        repeat (3) @(negedge clk);
        checks++;
        if (wq.size() != 8192) begin
            failures++;
            $display("FAIL full_count got=%0d exp=8192", wq.size());
        end
        bad = 0;
        zero_hits = 0;
        foreach (wq[i]) begin
            if (wq[i][44:32] == 13'd0) zero_hits++;
            if (i < 8192 && wq[i] !== {13'(i), img[i]}) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL full_data got=%0d_bad exp=0_bad", bad);
        end
        checks++;
        if (zero_hits != 1) begin
            failures++;
            $display("FAIL full_addr0_writes got=%0d exp=1", zero_hits);
        end
        checks++;
        if (wq.size() == 0 || wq[wq.size()-1][44:32] !== 13'd8191) begin
            failures++;
            $display("FAIL full_last_addr got=%h exp=1fff",
                     (wq.size() > 0) ? wq[wq.size()-1][44:32] : 13'h0);
        end
        checks++;
        if ({done, cpu_hold} !== 2'b10) begin
            failures++;
            $display("FAIL full_done got=%b exp=10", {done, cpu_hold});
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bad_csum();
        test_lengths();
        test_gaps();
        test_reset_abort();
        test_full_image();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
